// File: rtl/sram_col_ctrl.sv
// Single-column SRAM access sequencer: drives word lines and the write bitline
// pair through setup/pulse/hold phases and senses a per-row bitline pair on reads.
module sram_col_ctrl #(
  parameter int ROWS      = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int SENSE_CYC = 2,
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          wdata,
  output logic          ready,
  output logic          ack,
  output logic          rvalid,
  output logic          rdata,
  output logic          err,
  output real           row_wr [ROWS],
  output real           bl_wr,
  output real           blb_wr,
  input  real           bl_rd  [ROWS],
  input  real           blb_rd [ROWS]
);

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  localparam logic [7:0]  SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0]  PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0]  HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0]  SENSE_LD = 8'(SENSE_CYC - 1);
  localparam logic [AW:0] ROWS_W   = (AW + 1)'(ROWS);

  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_SENSE, DONE} state_t;

  state_t        state_r, state_s;
  logic [7:0]    cnt_r, cnt_s;
  logic          we_r, we_s;
  logic [AW-1:0] addr_r, addr_s;
  logic          wdata_r, wdata_s;
  logic          inrange_r, inrange_s;
  logic          rdata_s, err_s;
  logic          ready_s, ack_s, rvalid_s, drive_s;
  logic [1:0]    sense_s;
  real           row_s [ROWS];
  real           bl_s, blb_s;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < ROWS_W);
  endfunction

  // Returns {err, bit}: a valid pair has exactly one side at or above VTH.
  function automatic logic [1:0] sense_pair(input real bl, input real blb);
    logic hi_bl;
    logic hi_blb;
    hi_bl  = (bl >= VTH);
    hi_blb = (blb >= VTH);
    if (hi_bl && !hi_blb) begin
      return 2'b01;
    end else if (!hi_bl && hi_blb) begin
      return 2'b00;
    end else begin
      return 2'b10;
    end
  endfunction

  // Next-state, phase counter, access latch and next registered outputs.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    we_s      = we_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    inrange_s = inrange_r;
    rdata_s   = rdata;
    err_s     = err;
    sense_s   = 2'b00;
    case (state_r)
      IDLE: begin
        if (req) begin
          we_s      = we;
          addr_s    = addr;
          wdata_s   = wdata;
          inrange_s = addr_ok(addr);
          err_s     = !addr_ok(addr);
          if (we) begin
            state_s = W_SETUP;
            cnt_s   = SETUP_LD;
          end else begin
            state_s = R_SENSE;
            cnt_s   = SENSE_LD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      W_SETUP: begin
        if (cnt_r == 8'd0) begin
          state_s = W_PULSE;
          cnt_s   = PULSE_LD;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      W_PULSE: begin
        if (cnt_r == 8'd0) begin
          state_s = W_HOLD;
          cnt_s   = HOLD_LD;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      W_HOLD: begin
        if (cnt_r == 8'd0) begin
          state_s = DONE;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      R_SENSE: begin
        if (cnt_r == 8'd0) begin
          state_s = DONE;
          // Out-of-range reads keep the previous rdata; err is already set.
          if (inrange_r) begin
            sense_s = sense_pair(bl_rd[addr_r], blb_rd[addr_r]);
            rdata_s = sense_s[0];
            err_s   = err | sense_s[1];
          end else begin
            rdata_s = rdata;
          end
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase

    ready_s  = (state_s == IDLE);
    ack_s    = (state_s == DONE);
    rvalid_s = ack_s && !we_s;
    drive_s  = inrange_s && ((state_s == W_SETUP) || (state_s == W_PULSE) || (state_s == W_HOLD));
    bl_s     = drive_s ? (wdata_s ? VDD : VSS) : VSS;
    blb_s    = drive_s ? (wdata_s ? VSS : VDD) : VSS;
    for (int i = 0; i < ROWS; i++) begin
      row_s[i] = ((state_s == W_PULSE) && inrange_s && (addr_s == AW'(i))) ? VDD : VSS;
    end
  end

  // State, access latch and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      we_r      <= 1'b0;
      addr_r    <= {AW{1'b0}};
      wdata_r   <= 1'b0;
      inrange_r <= 1'b0;
      rdata     <= 1'b0;
      err       <= 1'b0;
      ready     <= 1'b1;
      ack       <= 1'b0;
      rvalid    <= 1'b0;
      bl_wr     <= VSS;
      blb_wr    <= VSS;
      for (int i = 0; i < ROWS; i++) begin
        row_wr[i] <= VSS;
      end
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      inrange_r <= inrange_s;
      rdata     <= rdata_s;
      err       <= err_s;
      ready     <= ready_s;
      ack       <= ack_s;
      rvalid    <= rvalid_s;
      bl_wr     <= bl_s;
      blb_wr    <= blb_s;
      for (int i = 0; i < ROWS; i++) begin
        row_wr[i] <= row_s[i];
      end
    end
  end

endmodule

// File: tb/tb_sram_col_ctrl.sv
// Directed plus randomized bench for sram_col_ctrl (ROWS=3 so out-of-range addresses exist);
// expectations come from a per-cycle timeline model of each access.
module tb_sram_col_ctrl;

  localparam int  ROWS = 3;
  localparam int  S = 1;
  localparam int  P = 2;
  localparam int  H = 1;
  localparam int  N = 2;
  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  logic       clk = 1'b0;
  logic       rst, req, we, wdata;
  logic [1:0] addr;
  logic       ready, ack, rvalid, rdata, err;
  real        row_wr [ROWS];
  real        bl_wr, blb_wr;
  real        bl_rd  [ROWS];
  real        blb_rd [ROWS];

  int   total  = 0;
  int   passed = 0;
  logic rdata_m;
  real  levels [5];

  always #5 clk = ~clk;

  sram_col_ctrl #(.ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .ack(ack), .rvalid(rvalid), .rdata(rdata), .err(err),
    .row_wr(row_wr), .bl_wr(bl_wr), .blb_wr(blb_wr),
    .bl_rd(bl_rd), .blb_rd(blb_rd)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_real(input string tag, input real obs, input real exp);
    total++;
    assert (obs == exp) passed++;
    else $error("FAIL %s: observed %f expected %f", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk_bit({tag, ".ready"}, ready, 1'b1);
    chk_bit({tag, ".ack"}, ack, 1'b0);
    chk_bit({tag, ".rvalid"}, rvalid, 1'b0);
    chk_bit({tag, ".rdata"}, rdata, rdata_m);
    chk_real({tag, ".bl_wr"}, bl_wr, VSS);
    chk_real({tag, ".blb_wr"}, blb_wr, VSS);
    for (int r = 0; r < ROWS; r++) begin
      chk_real($sformatf("%s.row_wr[%0d]", tag, r), row_wr[r], VSS);
    end
  endtask

  // Starts in an IDLE cycle, runs one access and ends in the following IDLE cycle.
  task automatic run_access(input logic w, input logic [1:0] a, input logic d, input bit keep);
    int   lat;
    logic ok, exp_rd, exp_err, hb, hbb, drv;
    real  exp_row, exp_bl, exp_blb;
    ok      = (a < ROWS);
    lat     = w ? (S + P + H + 1) : (N + 1);
    exp_rd  = rdata_m;
    exp_err = !ok;
    if (!w && ok) begin
      hb  = (bl_rd[a] >= VTH);
      hbb = (blb_rd[a] >= VTH);
      if (hb && !hbb) begin
        exp_rd = 1'b1;
      end else if (!hb && hbb) begin
        exp_rd = 1'b0;
      end else begin
        exp_rd  = 1'b0;
        exp_err = 1'b1;
      end
    end
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k == 1) begin
        if (keep) begin
          we = ~w; addr = a + 2'd1; wdata = ~d;
        end else begin
          req = 1'b0;
        end
      end
      chk_bit($sformatf("c%0d.ready", k), ready, 1'b0);
      chk_bit($sformatf("c%0d.ack", k), ack, (k == lat));
      chk_bit($sformatf("c%0d.rvalid", k), rvalid, (k == lat) && !w);
      chk_bit($sformatf("c%0d.rdata", k), rdata, (k == lat) ? exp_rd : rdata_m);
      if (k == lat) chk_bit("ack.err", err, exp_err);
      drv     = w && ok && (k <= S + P + H);
      exp_bl  = drv ? (d ? VDD : VSS) : VSS;
      exp_blb = drv ? (d ? VSS : VDD) : VSS;
      chk_real($sformatf("c%0d.bl_wr", k), bl_wr, exp_bl);
      chk_real($sformatf("c%0d.blb_wr", k), blb_wr, exp_blb);
      for (int r = 0; r < ROWS; r++) begin
        exp_row = (w && ok && (r == a) && (k > S) && (k <= S + P)) ? VDD : VSS;
        chk_real($sformatf("c%0d.row_wr[%0d]", k, r), row_wr[r], exp_row);
      end
    end
    rdata_m = exp_rd;
    step();
    check_idle("post");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    levels[0] = 0.0; levels[1] = 0.5; levels[2] = 0.8; levels[3] = 1.0; levels[4] = 1.5;
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 2'd0; wdata = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      bl_rd[r] = 0.0; blb_rd[r] = 0.0;
    end
    rdata_m = 1'b0;
    #1;
    step();
    step();
    check_idle("reset");
    chk_bit("reset.err", err, 1'b0);
    rst = 1'b0; req = 1'b0;

    // Directed accesses
    bl_rd[2] = 1.5; blb_rd[2] = 0.0;
    run_access(1'b1, 2'd2, 1'b1, 1'b0);
    run_access(1'b0, 2'd2, 1'b0, 1'b0);
    bl_rd[0] = 1.5; blb_rd[0] = 1.5;
    run_access(1'b0, 2'd0, 1'b0, 1'b0);
    run_access(1'b0, 2'd2, 1'b0, 1'b0);
    run_access(1'b1, 2'd3, 1'b1, 1'b0);
    run_access(1'b0, 2'd3, 1'b0, 1'b0);
    run_access(1'b1, 2'd0, 1'b0, 1'b0);

    // Reset in the middle of the word-line pulse
    req = 1'b1; we = 1'b1; addr = 2'd1; wdata = 1'b1;
    step();
    req = 1'b0;
    step();
    chk_real("pulse.row_wr[1]", row_wr[1], VDD);
    rst = 1'b1; req = 1'b1; we = 1'b0;
    rdata_m = 1'b0;
    step();
    check_idle("midrst");
    step();
    check_idle("rstreq");
    rst = 1'b0; req = 1'b0;

    // Back-to-back with req held high
    run_access(1'b1, 2'd1, 1'b0, 1'b1);
    run_access(1'b0, 2'd2, 1'b0, 1'b0);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < ROWS; r++) begin
        bl_rd[r]  = levels[$urandom_range(0, 4)];
        blb_rd[r] = levels[$urandom_range(0, 4)];
      end
      run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    req = 1'b0;
    step();
    check_idle("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
